// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack handshake between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS32 instruction fetch: owns the PC, fetches over req/ack, feeds the IF/ID register
// through a one-entry skid buffer, and redirects on taken branches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      imem,
    input  logic               id_stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic [5:0]         if_id_op,
    output logic [5:0]         if_id_func
);
    typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_pend_q, tgt_pend_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        req_q, req_d;
    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic        accept;

    assign tgt    = branch_target & ~32'h3;
    assign pc_inc = pc_q + 32'd4;
    assign accept = !valid_q || !id_stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_pend_d   = tgt_pend_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        // Default is a bubble unless decode is holding the current entry.
        valid_d      = id_stall ? valid_q : 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem.imem_ack && branch_taken) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                end else if (imem.imem_ack && accept) begin
                    instr_d = imem.imem_rdata;
                    pc4_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end else if (imem.imem_ack) begin
                    skid_instr_d = imem.imem_rdata;
                    skid_pc4_d   = pc_inc;
                    pc_d         = pc_inc;
                    valid_d      = valid_q;
                    state_d      = HOLD;
                end else if (branch_taken) begin
                    // Request must stay stable; remember where to go once it completes.
                    tgt_pend_d = tgt;
                    valid_d    = 1'b0;
                    state_d    = DROP;
                end
            end
            DROP: begin
                if (branch_taken) begin
                    tgt_pend_d = tgt;
                    valid_d    = 1'b0;
                end
                if (imem.imem_ack) begin
                    pc_d    = branch_taken ? tgt : tgt_pend_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!id_stall) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == FETCH) || (state_d == DROP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            tgt_pend_q   <= '0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc4_q        <= '0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_pend_q   <= tgt_pend_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            req_q        <= req_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc4      = pc4_q;
    assign if_id_op       = instr_q[31:26];
    assign if_id_func     = instr_q[5:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance at RESET_PC=0 plus a wrap instance at 0xFFFF_FFFC.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    fetch_stage_if m1();
    fetch_stage_if m2();

    logic        stall, bt;
    logic [31:0] btgt;
    logic        v1, v2;
    logic [31:0] i1, p1, i2, p2;
    logic [5:0]  op1, fn1, op2, fn2;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0230_4020 : (32'hA000_0000 | a);
    endfunction

    assign m1.imem_rdata = mem(m1.imem_addr);
    assign m2.imem_rdata = 32'h1234_5678;

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem(m1), .id_stall(stall), .branch_taken(bt),
        .branch_target(btgt), .if_id_valid(v1), .if_id_instr(i1), .if_id_pc4(p1),
        .if_id_op(op1), .if_id_func(fn1));

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem(m2), .id_stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .if_id_valid(v2), .if_id_instr(i2), .if_id_pc4(p2),
        .if_id_op(op2), .if_id_func(fn2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc4);
        chk({tag, ".valid"}, {31'd0, v1}, {31'd0, v});
        if (v) begin
            chk({tag, ".instr"}, i1, ins);
            chk({tag, ".pc4"}, p1, pc4);
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, m1.imem_req}, {31'd0, r});
        chk({tag, ".addr"}, m1.imem_addr, a);
    endtask

    initial begin
        stall = 0; bt = 0; btgt = 0; m1.imem_ack = 0; m2.imem_ack = 1;
        #1 rst = 1;
        #1;
        chk_req("rst", 1'b0, 32'h0);
        chk("rst.valid", {31'd0, v1}, 32'd0);
        chk("rst.instr", i1, 32'h0);
        chk("rst.pc4", p1, 32'h0);
        chk("rst.wrap_addr", m2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); @(negedge clk);
        rst = 0;
        // first edge: IDLE -> FETCH
        @(negedge clk);
        chk_req("c1", 1'b1, 32'h0);
        chk("wrap.c1_addr", m2.imem_addr, 32'hFFFF_FFFC);
        m1.imem_ack = 1;
        @(negedge clk);
        chk_req("c2", 1'b1, 32'h4);
        chk_if("c2", 1'b1, 32'h0230_4020, 32'h4);
        chk("c2.op", {26'd0, op1}, 32'h0);
        chk("c2.func", {26'd0, fn1}, 32'h20);
        chk("wrap.addr2", m2.imem_addr, 32'h0);
        chk("wrap.pc4", p2, 32'h0);
        @(negedge clk);
        chk_req("c3", 1'b1, 32'h8);
        chk_if("c3", 1'b1, 32'hA000_0004, 32'h8);
        chk("c3.op", {26'd0, op1}, 32'h28);
        // ack withheld for three edges on address 8
        m1.imem_ack = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_req("wait", 1'b1, 32'h8);
            chk_if("wait", 1'b0, 32'h0, 32'h0);
        end
        m1.imem_ack = 1;
        @(negedge clk);
        chk_req("ack8", 1'b1, 32'hC);
        chk_if("ack8", 1'b1, 32'hA000_0008, 32'hC);
        // stall four edges with ack high: one instr into skid, then HOLD
        stall = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_req("hold", 1'b0, 32'h10);
            chk_if("hold", 1'b1, 32'hA000_0008, 32'hC);
        end
        stall = 0;
        @(negedge clk);
        chk_req("drain", 1'b1, 32'h10);
        chk_if("drain", 1'b1, 32'hA000_000C, 32'h10);
        @(negedge clk);
        chk_req("resume", 1'b1, 32'h14);
        chk_if("resume", 1'b1, 32'hA000_0010, 32'h14);
        // redirect to 0x40 while fetch of 0x14 is outstanding
        m1.imem_ack = 0; bt = 1; btgt = 32'h40;
        @(negedge clk);
        bt = 0; btgt = 0;
        chk_req("drop1", 1'b1, 32'h14);
        chk_if("drop1", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_req("drop2", 1'b1, 32'h14);
        chk_if("drop2", 1'b0, 32'h0, 32'h0);
        m1.imem_ack = 1;
        @(negedge clk);
        chk_req("redir", 1'b1, 32'h40);
        chk_if("redir", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_req("tgt40", 1'b1, 32'h44);
        chk_if("tgt40", 1'b1, 32'hA000_0040, 32'h44);
        // same-cycle ack and redirect while stalled; target low bits dropped
        stall = 1; bt = 1; btgt = 32'h83;
        @(negedge clk);
        bt = 0; btgt = 0; stall = 0;
        chk_req("flush", 1'b1, 32'h80);
        chk_if("flush", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_req("tgt80", 1'b1, 32'h84);
        chk_if("tgt80", 1'b1, 32'hA000_0080, 32'h84);
        // enter HOLD, then reset asynchronously
        stall = 1;
        @(negedge clk);
        chk_req("hold2", 1'b0, 32'h88);
        #2 rst = 1;
        #1;
        chk_req("rst_hold", 1'b0, 32'h0);
        chk("rst_hold.valid", {31'd0, v1}, 32'd0);
        chk("rst_hold.instr", i1, 32'h0);
        chk("rst_hold.pc4", p1, 32'h0);
        stall = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_req("restart", 1'b1, 32'h0);
        // abandon a live request with reset
        #2 rst = 1;
        #1;
        chk_req("rst_req", 1'b0, 32'h0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_req("restart2", 1'b1, 32'h0);
        @(negedge clk);
        chk_if("restart2", 1'b1, 32'h0230_4020, 32'h4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
